// File: rtl/spi_flash_emu.sv
// spi_flash_emu: clocked SPI NOR-flash read responder (0x03 / 0x0B) serving an internal, parallel-preloaded byte array.
// Define SPI_FLASH_EMU_DUAL_EN to add the 0x3B dual-output fast read; without it 0x3B is an unknown command.
module spi_flash_emu #(
    parameter int MEM_BYTES    = 4096,
    parameter int ADDR_W       = 24,
    parameter int DUMMY_CYCLES = 8
) (
    input  logic                         wb_clk_i,
    input  logic                         wb_rst_i,
    input  logic                         spi_csb,
    input  logic                         spi_sck,
    input  logic                         spi_io0_i,
    output logic                         spi_io0_o,
    output logic                         spi_io0_oe,
    output logic                         spi_io1_o,
    output logic                         spi_io1_oe,
    input  logic                         load_en,
    input  logic [$clog2(MEM_BYTES)-1:0] load_addr,
    input  logic [7:0]                   load_data,
    output logic                         busy,
    output logic                         err
);
    localparam int          AW         = $clog2(MEM_BYTES);
    localparam logic [15:0] ADDR_LAST  = 16'(ADDR_W - 1);
    localparam logic [15:0] DUMMY_LAST = 16'((DUMMY_CYCLES > 0) ? DUMMY_CYCLES - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_DUMMY,
        S_DATA,
        S_IGNORE
    } state_t;

    logic          csb_m_q, csb_s_q;
    logic          sck_m_q, sck_s_q, sck_p_q;
    logic          io0_m_q, io0_s_q;
    logic          sck_rise, sck_fall;

    state_t        state_q, state_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [7:0]    cmd_q, cmd_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic          dummy_q, dummy_d;
    logic          io1_q, io1_d;
    logic          oe1_q, oe1_d;
    logic          busy_q, busy_d;
    logic          err_q, err_d;
    logic          load_ok;
    logic [7:0]    cmd_next;
    logic [7:0]    rd_shift;
    logic [7:0]    rd_byte;
`ifdef SPI_FLASH_EMU_DUAL_EN
    logic          dual_q, dual_d;
    logic          io0_q, io0_d;
    logic          oe0_q, oe0_d;
`endif

    logic [7:0]    mem_q [MEM_BYTES];

    assign sck_rise = sck_s_q & ~sck_p_q;
    assign sck_fall = ~sck_s_q & sck_p_q;
    assign rd_byte  = mem_q[ptr_q];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cmd_d    = cmd_q;
        ptr_d    = ptr_q;
        dummy_d  = dummy_q;
        io1_d    = io1_q;
        oe1_d    = oe1_q;
        busy_d   = ~csb_s_q;
        err_d    = err_q;
        load_ok  = 1'b0;
        cmd_next = {cmd_q[6:0], io0_s_q};
        rd_shift = 8'h00;
`ifdef SPI_FLASH_EMU_DUAL_EN
        dual_d   = dual_q;
        io0_d    = io0_q;
        oe0_d    = oe0_q;
`endif

        // The array may only change while the bus is idle; any other strobe is a harness error.
        if (load_en) begin
            if (state_q == S_IDLE && csb_s_q) begin
                load_ok = 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end

        // A deselect overrides any SCK edge seen in the same cycle.
        if (csb_s_q) begin
            state_d = S_IDLE;
            io1_d   = 1'b0;
            oe1_d   = 1'b0;
`ifdef SPI_FLASH_EMU_DUAL_EN
            io0_d   = 1'b0;
            oe0_d   = 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_CMD;
                    cnt_d   = '0;
                    cmd_d   = '0;
                    ptr_d   = '0;
                    dummy_d = 1'b0;
`ifdef SPI_FLASH_EMU_DUAL_EN
                    dual_d  = 1'b0;
`endif
                end
                S_CMD: begin
                    if (sck_rise) begin
                        cmd_d = cmd_next;
                        cnt_d = cnt_q + 16'd1;
                        if (cnt_q == 16'd7) begin
                            cnt_d = '0;
                            case (cmd_next)
                                8'h03: state_d = S_ADDR;
                                8'h0B: begin
                                    state_d = S_ADDR;
                                    dummy_d = 1'b1;
                                end
`ifdef SPI_FLASH_EMU_DUAL_EN
                                8'h3B: begin
                                    state_d = S_ADDR;
                                    dummy_d = 1'b1;
                                    dual_d  = 1'b1;
                                end
`endif
                                default: begin
                                    state_d = S_IGNORE;
                                    err_d   = 1'b1;
                                end
                            endcase
                        end
                    end
                end
                S_ADDR: begin
                    // Shifting through an AW-bit register keeps only the address modulo MEM_BYTES.
                    if (sck_rise) begin
                        ptr_d = {ptr_q[AW-2:0], io0_s_q};
                        cnt_d = cnt_q + 16'd1;
                        if (cnt_q == ADDR_LAST) begin
                            cnt_d   = '0;
                            state_d = (dummy_q && DUMMY_CYCLES > 0) ? S_DUMMY : S_DATA;
                        end
                    end
                end
                S_DUMMY: begin
                    if (sck_rise) begin
                        cnt_d = cnt_q + 16'd1;
                        if (cnt_q == DUMMY_LAST) begin
                            cnt_d   = '0;
                            state_d = S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (sck_fall) begin
`ifdef SPI_FLASH_EMU_DUAL_EN
                        if (dual_q) begin
                            rd_shift = rd_byte << {cnt_q[1:0], 1'b0};
                            io1_d    = rd_shift[7];
                            io0_d    = rd_shift[6];
                            oe1_d    = 1'b1;
                            oe0_d    = 1'b1;
                            if (cnt_q[1:0] == 2'd3) begin
                                cnt_d = '0;
                                ptr_d = ptr_q + AW'(1);
                            end else begin
                                cnt_d = cnt_q + 16'd1;
                            end
                        end else
`endif
                        begin
                            rd_shift = rd_byte << cnt_q[2:0];
                            io1_d    = rd_shift[7];
                            oe1_d    = 1'b1;
                            if (cnt_q[2:0] == 3'd7) begin
                                cnt_d = '0;
                                ptr_d = ptr_q + AW'(1);
                            end else begin
                                cnt_d = cnt_q + 16'd1;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            csb_m_q <= 1'b1;
            csb_s_q <= 1'b1;
            sck_m_q <= 1'b0;
            sck_s_q <= 1'b0;
            sck_p_q <= 1'b0;
            io0_m_q <= 1'b0;
            io0_s_q <= 1'b0;
            state_q <= S_IDLE;
            cnt_q   <= '0;
            cmd_q   <= '0;
            ptr_q   <= '0;
            dummy_q <= 1'b0;
            io1_q   <= 1'b0;
            oe1_q   <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef SPI_FLASH_EMU_DUAL_EN
            dual_q  <= 1'b0;
            io0_q   <= 1'b0;
            oe0_q   <= 1'b0;
`endif
        end else begin
            csb_m_q <= spi_csb;
            csb_s_q <= csb_m_q;
            sck_m_q <= spi_sck;
            sck_s_q <= sck_m_q;
            sck_p_q <= sck_s_q;
            io0_m_q <= spi_io0_i;
            io0_s_q <= io0_m_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cmd_q   <= cmd_d;
            ptr_q   <= ptr_d;
            dummy_q <= dummy_d;
            io1_q   <= io1_d;
            oe1_q   <= oe1_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
`ifdef SPI_FLASH_EMU_DUAL_EN
            dual_q  <= dual_d;
            io0_q   <= io0_d;
            oe0_q   <= oe0_d;
`endif
        end
    end

    // Array contents survive reset; a write coinciding with reset is dropped.
    always_ff @(posedge wb_clk_i) begin
        if (load_ok && !wb_rst_i) begin
            mem_q[load_addr] <= load_data;
        end
    end

    assign spi_io1_o  = io1_q;
    assign spi_io1_oe = oe1_q;
    assign busy       = busy_q;
    assign err        = err_q;
`ifdef SPI_FLASH_EMU_DUAL_EN
    assign spi_io0_o  = io0_q;
    assign spi_io0_oe = oe0_q;
`else
    assign spi_io0_o  = 1'b0;
    assign spi_io0_oe = 1'b0;
`endif

endmodule
